inst_mem_arbiter: RTL and testbench
===================================

Name: inst_mem_arbiter

Overview:
Shares one single-port synchronous instruction RAM (1-cycle read latency) between two requesters: the core fetch stage (read-only) and the program loader/debug port (read/write). Fetch has priority; a starvation counter guarantees the loader forward progress. A lock mode gives the loader exclusive access for bulk program download while fetch is stalled. The block sits between the fetch stage, the loader and the instruction RAM macro.

Parameters:
ADDR_W, `IM_ADDR_BIT, word-address width of the instruction RAM
MAX_WAIT, 4, loader cycles waited (1..15) before the loader overrides fetch priority

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch read request
f_addr  in  ADDR_W  fetch word address
f_gnt  out  1  fetch request accepted this cycle (combinational)
f_rvalid  out  1  fetch read data valid
f_rdata  out  32  fetch read data
l_req  in  1  loader request
l_we  in  1  loader write enable (1 = write, 0 = read)
l_addr  in  ADDR_W  loader word address
l_wdata  in  32  loader write data
l_lock  in  1  loader requests exclusive ownership
l_gnt  out  1  loader request accepted this cycle (combinational)
l_rvalid  out  1  loader read data valid
l_rdata  out  32  loader read data
locked  out  1  arbiter in LOCKED state
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid cycle after mem_en with mem_we=0

Behaviour:
- Reset (rst_n=0, async): state NORMAL, wait_cnt=0, f_rvalid=l_rvalid=0, locked=0; with requests low all combinational outputs are 0. Reset mid-read drops the pending rvalid; no response is delivered after reset.
- States: NORMAL, LOCKED. NORMAL->LOCKED at clock edge when l_lock=1. LOCKED->NORMAL at clock edge when l_lock=0. locked = (state==LOCKED), registered.
- Grant, NORMAL: if l_req && wait_cnt==MAX_WAIT -> l_gnt=1, f_gnt=0; else if f_req -> f_gnt=1; else if l_req -> l_gnt=1. At most one grant per cycle.
- Grant, LOCKED: f_gnt=0 always; l_gnt=l_req.
- Granted request drives RAM the same cycle: mem_en=1, mem_addr/mem_we/mem_wdata from the winner (fetch: mem_we=0, mem_wdata=0). No grant: mem_en=0, mem_we=0; mem_addr/mem_wdata = 0.
- Response: registered owner tag; f_rvalid=1 exactly one cycle after f_gnt; l_rvalid=1 exactly one cycle after l_gnt with l_we=0. Loader writes produce no rvalid. f_rdata=l_rdata=mem_rdata, meaningful only when the matching rvalid=1.
- Throughput: one access per cycle, back-to-back grants allowed; requester holds req/addr/data until its gnt.
- wait_cnt (4 bits): +1 per cycle with l_req=1 && l_gnt=0, saturating at MAX_WAIT. Cleared on l_gnt or l_req=0. Held at 0 in LOCKED.
- Simultaneous: l_lock rising while fetch granted: the grant completes normally and its rvalid is still delivered in the first LOCKED cycle. A write and read to the same address in consecutive cycles returns the new data (RAM ordering). f_req held during LOCKED is stalled, not dropped.

Test Plan:
- Reset: rst_n=0 with f_req=l_req=1 -> all outputs 0; release -> f_gnt=1 in the first cycle.
- Fetch only: f_req=1, f_addr=0x000..0x003 consecutive -> f_gnt=1 every cycle, f_rvalid=1 one cycle later, f_rdata = preloaded words in order, no bubbles.
- Contention/starvation: f_req=1 continuously, l_req=1 l_we=0 l_addr=0x010 -> f_gnt for 4 cycles, l_gnt=1 in 5th cycle (MAX_WAIT=4), l_rvalid next cycle with mem[0x010], f_gnt resumes.
- Lock download: l_lock=1, writes 0xDEADBEEF->0x020 and 0x12345678->0x021 while f_req=1 -> locked=1 next edge, f_gnt=0 throughout, no l_rvalid; l_lock=0 -> fetch reads 0x020 returning 0xDEADBEEF.
- Lock edge: f_gnt at cycle N with l_lock rising at N -> f_rvalid=1 at N+1 while locked=1.
- Async reset mid-read: assert rst_n=0 between l_gnt (read) and the following edge -> l_rvalid stays 0, wait_cnt=0, state NORMAL.

Source files
------------

// File: rtl/inst_mem_arbiter.sv
// Two-requester arbiter for a single-port instruction RAM. Fetch normally wins;
// the loader gets a turn after MAX_WAIT stalled cycles and can lock fetch out.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 10
`endif

module inst_mem_arbiter #(
  parameter int ADDR_W   = `IM_ADDR_BIT,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {NORMAL = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t      state_q;
  logic [3:0]  wait_q, wait_d;
  logic        f_rvalid_q, l_rvalid_q;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == LOCKED) begin
        l_gnt = l_req;
      end else if (l_req && (wait_q == MAX_W)) begin
        l_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end else begin
        l_gnt = l_req;
      end
    end
  end

  always_comb begin
    mem_en    = f_gnt | l_gnt;
    mem_we    = l_gnt & l_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (l_gnt) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_q == LOCKED) || !l_req || l_gnt) begin
      wait_d = '0;
    end else if (wait_q < MAX_W) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      wait_q     <= '0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      state_q    <= l_lock ? LOCKED : NORMAL;
      wait_q     <= wait_d;
      f_rvalid_q <= f_gnt;
      l_rvalid_q <= l_gnt & ~l_we;
    end
  end

  assign locked   = (state_q == LOCKED);
  assign f_rvalid = f_rvalid_q;
  assign l_rvalid = l_rvalid_q;
  assign f_rdata  = mem_rdata;
  assign l_rdata  = mem_rdata;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Bench for inst_mem_arbiter: directed vector table, reset corner cases and a
// randomized run against a transaction-level model with its own memory image.
module tb_inst_mem_arbiter;

  localparam int AW = 10;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [AW-1:0] f_addr = '0, l_addr = '0;
  logic [31:0]   l_wdata = '0;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid, locked, mem_en, mem_we;
  logic [31:0]   f_rdata, l_rdata, mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  inst_mem_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .locked(locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Instruction RAM macro stand-in: synchronous, one-cycle read latency.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who may use the RAM this cycle, what each
  // requester is owed next cycle, and a private copy of memory contents.
  logic [31:0] shadow [1024];
  bit          m_locked, m_fpend, m_lpend;
  int          m_waited;
  logic [31:0] m_fexp, m_lexp;
  logic        s_fg, s_lg, s_frv, s_lrv, s_lk;
  logic [31:0] s_frd, s_lrd;

  task automatic model_reset();
    m_locked = 0; m_fpend = 0; m_lpend = 0; m_waited = 0;
  endtask

  // Drive one cycle of inputs, check mid-cycle, then advance to just after the edge.
  task automatic cycle(input logic fr, input logic [AW-1:0] fa, input logic lr, input logic lwe,
                       input logic [AW-1:0] la, input logic [31:0] wd, input logic lk);
    bit loader_turn, fetch_turn;
    f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = wd; l_lock = lk;
    if (m_locked) begin
      fetch_turn = 0; loader_turn = lr;
    end else begin
      loader_turn = lr && (m_waited >= MW || !fr);
      fetch_turn  = fr && !loader_turn;
    end
    #4;
    s_fg = f_gnt; s_lg = l_gnt; s_frv = f_rvalid; s_lrv = l_rvalid; s_lk = locked;
    s_frd = f_rdata; s_lrd = l_rdata;
    chk1("f_gnt", f_gnt, fetch_turn);
    chk1("l_gnt", l_gnt, loader_turn);
    chk1("f_rvalid", f_rvalid, m_fpend);
    chk1("l_rvalid", l_rvalid, m_lpend);
    chk1("locked", locked, m_locked);
    chk1("mem_en", mem_en, fetch_turn || loader_turn);
    chk1("mem_we", mem_we, loader_turn && lwe);
    chk32("mem_addr", 32'(mem_addr), fetch_turn ? 32'(fa) : (loader_turn ? 32'(la) : 32'd0));
    chk32("mem_wdata", mem_wdata, loader_turn ? wd : 32'd0);
    if (m_fpend) chk32("f_rdata", f_rdata, m_fexp);
    if (m_lpend) chk32("l_rdata", l_rdata, m_lexp);
    @(posedge clk); #1;
    m_fpend = fetch_turn;
    m_fexp  = shadow[fa];
    m_lpend = loader_turn && !lwe;
    m_lexp  = shadow[la];
    if (loader_turn && lwe) shadow[la] = wd;
    if (m_locked || !lr || loader_turn) m_waited = 0;
    else if (m_waited < MW) m_waited++;
    m_locked = lk;
  endtask

  typedef struct {
    logic          fr;
    logic [AW-1:0] fa;
    logic          lr, lwe;
    logic [AW-1:0] la;
    logic [31:0]   wd;
    logic          lk;
    logic          e_fg, e_lg, e_frv, e_lrv, e_lk;
    logic          cd;
    logic [31:0]   e_rd;
  } vec_t;

  vec_t tbl [19];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = 32'h1000_0000 | 32'(i);
      shadow[i] = 32'h1000_0000 | 32'(i);
    end

    //            fr fa      lr lwe la      wd            lk  fg lg frv lrv lk cd rd
    tbl[0]  = '{1, 10'h000, 1, 0, 10'h010, 32'h0,        0,  1, 0, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{1, 10'h001, 1, 0, 10'h010, 32'h0,        0,  1, 0, 1, 0, 0, 1, 32'h1000_0000};
    tbl[2]  = '{1, 10'h002, 1, 0, 10'h010, 32'h0,        0,  1, 0, 1, 0, 0, 1, 32'h1000_0001};
    tbl[3]  = '{1, 10'h003, 1, 0, 10'h010, 32'h0,        0,  1, 0, 1, 0, 0, 1, 32'h1000_0002};
    tbl[4]  = '{1, 10'h004, 1, 0, 10'h010, 32'h0,        0,  0, 1, 1, 0, 0, 1, 32'h1000_0003};
    tbl[5]  = '{1, 10'h004, 0, 0, 10'h000, 32'h0,        0,  1, 0, 0, 1, 0, 1, 32'h1000_0010};
    tbl[6]  = '{1, 10'h005, 0, 0, 10'h000, 32'h0,        0,  1, 0, 1, 0, 0, 1, 32'h1000_0004};
    tbl[7]  = '{1, 10'h006, 0, 0, 10'h000, 32'h0,        0,  1, 0, 1, 0, 0, 1, 32'h1000_0005};
    tbl[8]  = '{1, 10'h007, 1, 1, 10'h020, 32'hDEADBEEF, 1,  1, 0, 1, 0, 0, 1, 32'h1000_0006};
    tbl[9]  = '{1, 10'h008, 1, 1, 10'h020, 32'hDEADBEEF, 1,  0, 1, 1, 0, 1, 1, 32'h1000_0007};
    tbl[10] = '{1, 10'h008, 1, 1, 10'h021, 32'h12345678, 1,  0, 1, 0, 0, 1, 0, 32'h0};
    tbl[11] = '{1, 10'h008, 0, 0, 10'h000, 32'h0,        1,  0, 0, 0, 0, 1, 0, 32'h0};
    tbl[12] = '{1, 10'h008, 0, 0, 10'h000, 32'h0,        0,  0, 0, 0, 0, 1, 0, 32'h0};
    tbl[13] = '{1, 10'h008, 0, 0, 10'h000, 32'h0,        0,  1, 0, 0, 0, 0, 0, 32'h0};
    tbl[14] = '{1, 10'h020, 0, 0, 10'h000, 32'h0,        0,  1, 0, 1, 0, 0, 1, 32'h1000_0008};
    tbl[15] = '{1, 10'h021, 0, 0, 10'h000, 32'h0,        0,  1, 0, 1, 0, 0, 1, 32'hDEADBEEF};
    tbl[16] = '{0, 10'h000, 1, 1, 10'h030, 32'hCAFEF00D, 0,  0, 1, 1, 0, 0, 1, 32'h12345678};
    tbl[17] = '{0, 10'h000, 1, 0, 10'h030, 32'h0,        0,  0, 1, 0, 0, 0, 0, 32'h0};
    tbl[18] = '{0, 10'h000, 0, 0, 10'h000, 32'h0,        0,  0, 0, 0, 1, 0, 1, 32'hCAFEF00D};

    // Reset held with both requesters asserting.
    f_req = 1; l_req = 1;
    #1 rst_n = 0;
    #2;
    chk1("rst f_gnt", f_gnt, 1'b0);
    chk1("rst l_gnt", l_gnt, 1'b0);
    chk1("rst f_rvalid", f_rvalid, 1'b0);
    chk1("rst l_rvalid", l_rvalid, 1'b0);
    chk1("rst locked", locked, 1'b0);
    chk1("rst mem_en", mem_en, 1'b0);
    chk1("rst mem_we", mem_we, 1'b0);
    chk32("rst mem_addr", 32'(mem_addr), 32'd0);
    chk32("rst mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    model_reset();

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].fr, tbl[i].fa, tbl[i].lr, tbl[i].lwe, tbl[i].la, tbl[i].wd, tbl[i].lk);
      chk1($sformatf("vec%0d f_gnt", i), s_fg, tbl[i].e_fg);
      chk1($sformatf("vec%0d l_gnt", i), s_lg, tbl[i].e_lg);
      chk1($sformatf("vec%0d f_rvalid", i), s_frv, tbl[i].e_frv);
      chk1($sformatf("vec%0d l_rvalid", i), s_lrv, tbl[i].e_lrv);
      chk1($sformatf("vec%0d locked", i), s_lk, tbl[i].e_lk);
      if (tbl[i].cd) chk32($sformatf("vec%0d rdata", i), s_frv ? s_frd : s_lrd, tbl[i].e_rd);
    end

    // Async reset between a locked loader read grant and the next edge.
    cycle(0, 10'h0, 0, 0, 10'h0, 32'h0, 1);
    f_req = 1; f_addr = 10'h3; l_req = 1; l_we = 0; l_addr = 10'h5; l_lock = 1;
    #2;
    chk1("midrd l_gnt", l_gnt, 1'b1);
    chk1("midrd locked", locked, 1'b1);
    #1 rst_n = 0;
    #1;
    chk1("midrd rst l_gnt", l_gnt, 1'b0);
    chk1("midrd rst mem_en", mem_en, 1'b0);
    chk1("midrd rst locked", locked, 1'b0);
    @(posedge clk); #1;
    chk1("midrd l_rvalid", l_rvalid, 1'b0);
    chk1("midrd f_rvalid", f_rvalid, 1'b0);
    chk1("midrd locked after", locked, 1'b0);
    f_req = 0; l_req = 0; l_lock = 0;
    rst_n = 1;
    model_reset();
    cycle(1, 10'h3, 0, 0, 10'h0, 32'h0, 0);
    chk1("post-rst f_gnt", s_fg, 1'b1);

    // Reset pulse after three starved loader cycles restarts the wait count.
    for (int i = 0; i < 3; i++) cycle(1, 10'(i), 1, 0, 10'h011, 32'h0, 0);
    #1 rst_n = 0;
    #1 rst_n = 1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 10'(i), 1, 0, 10'h011, 32'h0, 0);
      chk1($sformatf("restart wait l_gnt%0d", i), s_lg, (i == 4));
    end
    cycle(1, 10'h4, 0, 0, 10'h0, 32'h0, 0);
    chk1("restart l_rvalid", s_lrv, 1'b1);
    chk32("restart l_rdata", s_lrd, 32'h1000_0011);

    // Randomized traffic; requesters hold their request until granted.
    begin
      logic          rfr, rlr, rlwe, rlk;
      logic [AW-1:0] rfa, rla;
      logic [31:0]   rwd;
      bit            fdone, ldone;
      rfr = 0; rlr = 0; rlwe = 0; rlk = 0; rfa = '0; rla = '0; rwd = '0;
      fdone = 1; ldone = 1;
      for (int n = 0; n < 600; n++) begin
        if (fdone) begin
          rfr = ($urandom_range(0, 3) != 0);
          rfa = 10'($urandom_range(0, 15));
        end
        if (ldone) begin
          rlr  = ($urandom_range(0, 1) != 0);
          rlwe = ($urandom_range(0, 2) == 0);
          rla  = 10'($urandom_range(0, 15));
          rwd  = $urandom;
        end
        if ($urandom_range(0, 15) == 0) rlk = ~rlk;
        if (n >= 590) rlk = 0;
        cycle(rfr, rfa, rlr, rlwe, rla, rwd, rlk);
        fdone = !rfr || s_fg;
        ldone = !rlr || s_lg;
      end
      cycle(0, 10'h0, 0, 0, 10'h0, 32'h0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
